pipe_collision_scorer: RTL and testbench

Downstream consumer of the pipe generator's `pipe_x` and `pipe_y` outputs. Each clock it compares the bird's bounding box against the current pipe column, the pipe gap, and the floor. It runs the game-state FSM (idle / play / hit / over) and counts pipes passed as a two-digit saturating BCD score for the display stage. It owns the decision that ends a round. It does not move pipes or the bird.

---
 rtl/pipe_collision_scorer_pkg.sv | 23 ++
 rtl/pipe_collision_scorer_if.sv | 23 ++
 rtl/bcd_counter2.sv | 58 +++++
 rtl/pipe_collision_scorer.sv | 171 +++++++++++++++++
 tb/tb_pipe_collision_scorer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_collision_scorer_pkg.sv
// Shared flappy game types and default geometry used by the scorer, the pipe generator and the renderer.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_e;

  localparam int BIRD_X  = 160;
  localparam int BIRD_W  = 24;
  localparam int BIRD_H  = 24;
  localparam int PIPE_W  = 52;
  localparam int GAP_H   = 120;
  localparam int FLOOR_Y = 440;

  // Packed BCD compares correctly as plain unsigned when both digits are valid
  function automatic logic [7:0] bcd_max(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_collision_scorer_if.sv
// Game-side bus of the scorer: bird/pipe geometry in, state and score out.
interface pipe_collision_scorer_if;
  logic        bird_move;
  logic [10:0] bird_y;
  logic [10:0] pipe_x;
  logic [10:0] pipe_y;
  logic [1:0]  state;
  logic        collision;
  logic        game_over;
  logic        score_pulse;
  logic [7:0]  score_bcd;
  logic [7:0]  high_score_bcd;

  modport master (
    output bird_move, bird_y, pipe_x, pipe_y,
    input  state, collision, game_over, score_pulse, score_bcd, high_score_bcd
  );

  modport slave (
    input  bird_move, bird_y, pipe_x, pipe_y,
    output state, collision, game_over, score_pulse, score_bcd, high_score_bcd
  );
endinterface

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter, synchronous clear, sticky at 99, one-cycle pulse per real increment.
module bcd_counter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] bcd,
  output logic       inc_done
);

  logic [3:0] ones_r;
  logic [3:0] tens_r;
  logic       done_r;
  logic [3:0] ones_nx_s;
  logic [3:0] tens_nx_s;
  logic       done_nx_s;
  logic       at_max_s;

  assign at_max_s = (tens_r == 4'd9) && (ones_r == 4'd9);

  // Next digits: clear beats increment, and an increment at 99 is swallowed
  always_comb begin
    ones_nx_s = ones_r;
    tens_nx_s = tens_r;
    done_nx_s = 1'b0;
    if (clr) begin
      ones_nx_s = 4'd0;
      tens_nx_s = 4'd0;
    end else if (inc && !at_max_s) begin
      done_nx_s = 1'b1;
      if (ones_r == 4'd9) begin
        ones_nx_s = 4'd0;
        tens_nx_s = tens_r + 4'd1;
      end else begin
        ones_nx_s = ones_r + 4'd1;
      end
    end else begin
      done_nx_s = 1'b0;
    end
  end

  // Digit and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_r <= 4'd0;
      tens_r <= 4'd0;
      done_r <= 1'b0;
    end else begin
      ones_r <= ones_nx_s;
      tens_r <= tens_nx_s;
      done_r <= done_nx_s;
    end
  end

  assign bcd      = {tens_r, ones_r};
  assign inc_done = done_r;

endmodule

// File: rtl/pipe_collision_scorer.sv
// Bird vs pipe/floor collision, game-state FSM and BCD scoring.
// Optional HIGH_SCORE_EN keeps a best score across rounds.
module pipe_collision_scorer
  import flappy_pkg::*;
#(
  parameter int BIRD_X      = flappy_pkg::BIRD_X,
  parameter int BIRD_W      = flappy_pkg::BIRD_W,
  parameter int BIRD_H      = flappy_pkg::BIRD_H,
  parameter int PIPE_W      = flappy_pkg::PIPE_W,
  parameter int GAP_H       = flappy_pkg::GAP_H,
  parameter int FLOOR_Y     = flappy_pkg::FLOOR_Y,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RESET_GAME,
  pipe_collision_scorer_if.slave  bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [11:0] BIRD_L_C = 12'(BIRD_X);
  localparam logic [11:0] BIRD_R_C = 12'(BIRD_X + BIRD_W);
  localparam logic [11:0] FLOOR_C  = 12'(FLOOR_Y);

  game_state_e       state_r;
  game_state_e       state_nx_s;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_nx_s;
  logic              collision_r;
  logic              collision_nx_s;
  logic              game_over_r;
  logic              ahead_q_r;
  logic              bird_move_q_r;
  logic              inc_s;
  logic [7:0]        score_bcd_s;
  logic              score_pulse_s;
  logic [7:0]        high_score_s;

  logic [11:0] pipe_l_s;
  logic [11:0] pipe_r_s;
  logic [11:0] bird_top_s;
  logic [11:0] bird_bot_s;
  logic [11:0] gap_top_s;
  logic [11:0] gap_bot_s;
  logic        x_ovl_s;
  logic        y_out_s;
  logic        floor_hit_s;
  logic        hit_now_s;
  logic        ahead_now_s;
  logic        pass_s;
  logic        flap_s;

  // 12-bit zero-extended sums so a pipe near x=2047 cannot wrap into the bird
  assign pipe_l_s   = {1'b0, bus.pipe_x};
  assign pipe_r_s   = pipe_l_s + 12'(PIPE_W);
  assign bird_top_s = {1'b0, bus.bird_y};
  assign bird_bot_s = bird_top_s + 12'(BIRD_H);
  assign gap_top_s  = {1'b0, bus.pipe_y};
  assign gap_bot_s  = gap_top_s + 12'(GAP_H);

  assign x_ovl_s     = (BIRD_R_C > pipe_l_s) && (pipe_r_s > BIRD_L_C);
  assign y_out_s     = (bird_top_s < gap_top_s) || (bird_bot_s > gap_bot_s);
  assign floor_hit_s = (bird_bot_s >= FLOOR_C);
  assign hit_now_s   = (x_ovl_s && y_out_s) || floor_hit_s;
  assign ahead_now_s = (pipe_r_s > BIRD_L_C);
  // Only the 1->0 transition scores; a regenerated pipe gives 0->1
  assign pass_s      = ahead_q_r && !ahead_now_s;
  assign flap_s      = bus.bird_move && !bird_move_q_r;

  // Next state, hold counter and collision pulse; round restart overrides everything
  always_comb begin
    state_nx_s     = state_r;
    hold_nx_s      = hold_r;
    collision_nx_s = 1'b0;
    inc_s          = 1'b0;
    if (RESET_GAME) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (flap_s) begin
            state_nx_s = PLAY;
          end else begin
            state_nx_s = IDLE;
          end
        end
        PLAY: begin
          if (hit_now_s) begin
            state_nx_s     = HIT;
            collision_nx_s = 1'b1;
            hold_nx_s      = HOLD_LOAD;
          end else if (pass_s) begin
            inc_s = 1'b1;
          end else begin
            inc_s = 1'b0;
          end
        end
        HIT: begin
          if (hold_r == '0) begin
            state_nx_s = OVER;
          end else begin
            hold_nx_s = hold_r - HOLD_W'(1);
          end
        end
        OVER: begin
          state_nx_s = OVER;
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // FSM and edge-detect registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      hold_r        <= '0;
      collision_r   <= 1'b0;
      game_over_r   <= 1'b0;
      ahead_q_r     <= 1'b0;
      bird_move_q_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      hold_r        <= hold_nx_s;
      collision_r   <= collision_nx_s;
      game_over_r   <= (state_nx_s == OVER);
      ahead_q_r     <= ahead_now_s;
      bird_move_q_r <= bus.bird_move;
    end
  end

  bcd_counter2 u_score (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (RESET_GAME),
    .inc      (inc_s),
    .bcd      (score_bcd_s),
    .inc_done (score_pulse_s)
  );

`ifdef HIGH_SCORE_EN
  logic [7:0] high_score_r;

  // Best score latches on entry to OVER; only the hard reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_score_r <= 8'h00;
    end else if ((state_r != OVER) && (state_nx_s == OVER)) begin
      high_score_r <= bcd_max(high_score_r, score_bcd_s);
    end else begin
      high_score_r <= high_score_r;
    end
  end

  assign high_score_s = high_score_r;
`else
  assign high_score_s = 8'h00;
`endif

  assign bus.state          = state_r;
  assign bus.collision      = collision_r;
  assign bus.game_over      = game_over_r;
  assign bus.score_pulse    = score_pulse_s;
  assign bus.score_bcd      = score_bcd_s;
  assign bus.high_score_bcd = high_score_s;

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Directed bench for pipe_collision_scorer; high-score expectations follow HIGH_SCORE_EN.
module tb_pipe_collision_scorer;

  logic clk;
  logic rst;
  logic RESET_GAME;
  int   checks;
  int   errors;

  pipe_collision_scorer_if bus ();

  pipe_collision_scorer dut (
    .clk        (clk),
    .rst        (rst),
    .RESET_GAME (RESET_GAME),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round();
    RESET_GAME    = 1'b1;
    bus.bird_move = 1'b0;
    bus.bird_y    = 11'd200;
    bus.pipe_y    = 11'd180;
    bus.pipe_x    = 11'd300;
    step();
    RESET_GAME = 1'b0;
    step();
    bus.bird_move = 1'b1;
    step();
  endtask

  task automatic do_passes(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      bus.pipe_x = 11'd100;
      step();
      if (bus.score_pulse === 1'b1) pulses++;
      bus.pipe_x = 11'd200;
      step();
      if (bus.score_pulse === 1'b1) pulses++;
    end
  endtask

  task automatic wait_over();
    int n;
    n = 0;
    while (bus.game_over !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (bus.game_over !== 1'b1) begin
      errors++;
      $display("FAIL wait_over: game_over=%b after %0d cycles, required 1", bus.game_over, n);
    end
  endtask

  task automatic end_round();
    bus.bird_y = 11'd416;
    bus.pipe_x = 11'd300;
    step();
    checks++;
    if (bus.state !== 2'd2) begin
      errors++;
      $display("FAIL end_round_hit: state=%0d required 2", bus.state);
    end
    wait_over();
    bus.bird_y = 11'd200;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    RESET_GAME    = 1'b0;
    bus.bird_move = 1'b0;
    bus.bird_y    = 11'd200;
    bus.pipe_y    = 11'd180;
    bus.pipe_x    = 11'd300;
    #22;
    checks++;
    if ({bus.state, bus.collision, bus.game_over, bus.score_pulse} !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctrl: state/col/go/pulse=%b required 00000",
               {bus.state, bus.collision, bus.game_over, bus.score_pulse});
    end
    checks++;
    if ({bus.score_bcd, bus.high_score_bcd} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_score: got %h required 0000", {bus.score_bcd, bus.high_score_bcd});
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_start();
    step();
    step();
    checks++;
    if (bus.state !== 2'd0 || bus.score_pulse !== 1'b0 || bus.collision !== 1'b0) begin
      errors++;
      $display("FAIL pre_flap: state=%0d pulse=%b col=%b required 0/0/0",
               bus.state, bus.score_pulse, bus.collision);
    end
    bus.bird_move = 1'b1;
    step();
    checks++;
    if (bus.state !== 2'd1) begin
      errors++;
      $display("FAIL flap_start: state=%0d required 1", bus.state);
    end
  endtask

  task automatic test_pass();
    int px;
    for (int i = 0; i <= 10; i++) begin
      px = 300 - 20 * i;
      bus.pipe_x = 11'(px);
      step();
      checks++;
      if (bus.score_pulse !== (px == 100)) begin
        errors++;
        $display("FAIL pass_pulse: pipe_x=%0d pulse=%b required %b", px, bus.score_pulse, (px == 100));
      end
    end
    checks++;
    if (bus.score_bcd !== 8'h01 || bus.state !== 2'd1 || bus.collision !== 1'b0) begin
      errors++;
      $display("FAIL pass_score: score=%h state=%0d col=%b required 01/1/0",
               bus.score_bcd, bus.state, bus.collision);
    end
  endtask

  task automatic test_collision();
    logic bad;
    bus.bird_y = 11'd100;
    bus.pipe_x = 11'd170;
    step();
    checks++;
    if (bus.collision !== 1'b1 || bus.state !== 2'd2 || bus.score_bcd !== 8'h01) begin
      errors++;
      $display("FAIL pipe_hit: col=%b state=%0d score=%h required 1/2/01",
               bus.collision, bus.state, bus.score_bcd);
    end
    step();
    checks++;
    if (bus.collision !== 1'b0 || bus.game_over !== 1'b0) begin
      errors++;
      $display("FAIL col_pulse: col=%b go=%b required 0/0", bus.collision, bus.game_over);
    end
    bad = 1'b0;
    for (int k = 2; k <= 15; k++) begin
      step();
      if (bus.game_over !== 1'b0 || bus.state !== 2'd2) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL hit_hold: left HIT early, state=%0d required 2", bus.state);
    end
    step();
    checks++;
    if (bus.game_over !== 1'b1 || bus.state !== 2'd3) begin
      errors++;
      $display("FAIL over_entry: go=%b state=%0d required 1/3", bus.game_over, bus.state);
    end
    bus.bird_move = 1'b0;
    step();
    bus.bird_move = 1'b1;
    step();
    checks++;
    if (bus.state !== 2'd3) begin
      errors++;
      $display("FAIL over_flap: state=%0d required 3", bus.state);
    end
    checks++;
`ifdef HIGH_SCORE_EN
    if (bus.high_score_bcd !== 8'h01) begin
      errors++;
      $display("FAIL hs_first: got %h required 01", bus.high_score_bcd);
    end
`else
    if (bus.high_score_bcd !== 8'h00) begin
      errors++;
      $display("FAIL hs_off: got %h required 00", bus.high_score_bcd);
    end
`endif
  endtask

  task automatic test_floor();
    bus.bird_y = 11'd200;
    bus.pipe_x = 11'd300;
    RESET_GAME = 1'b1;
    step();
    checks++;
    if (bus.state !== 2'd0 || bus.score_bcd !== 8'h00 || bus.game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart: state=%0d score=%h go=%b required 0/00/0",
               bus.state, bus.score_bcd, bus.game_over);
    end
    RESET_GAME = 1'b0;
    step();
    step();
    checks++;
    if (bus.state !== 2'd0) begin
      errors++;
      $display("FAIL held_level: state=%0d required 0", bus.state);
    end
    bus.bird_move = 1'b0;
    step();
    bus.bird_move = 1'b1;
    step();
    bus.bird_y = 11'd415;
    bus.pipe_x = 11'd200;
    step();
    checks++;
    if (bus.state !== 2'd1) begin
      errors++;
      $display("FAIL floor_edge: state=%0d required 1", bus.state);
    end
    bus.bird_y = 11'd416;
    bus.pipe_x = 11'd100;
    step();
    checks++;
    if (bus.state !== 2'd2 || bus.collision !== 1'b1 || bus.score_bcd !== 8'h00 || bus.score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL floor_pass_hit: state=%0d col=%b score=%h pulse=%b required 2/1/00/0",
               bus.state, bus.collision, bus.score_bcd, bus.score_pulse);
    end
    wait_over();
    bus.bird_y = 11'd200;
  endtask

  task automatic test_saturate();
    int p;
    start_round();
    do_passes(99, p);
    checks++;
    if (p != 99 || bus.score_bcd !== 8'h99) begin
      errors++;
      $display("FAIL count_99: pulses=%0d score=%h required 99/99", p, bus.score_bcd);
    end
    bus.pipe_x = 11'd100;
    step();
    checks++;
    if (bus.score_bcd !== 8'h99 || bus.score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL saturate: score=%h pulse=%b required 99/0", bus.score_bcd, bus.score_pulse);
    end
    bus.pipe_x = 11'd200;
    step();
    RESET_GAME = 1'b1;
    step();
    RESET_GAME = 1'b0;
    checks++;
    if (bus.state !== 2'd0 || bus.score_bcd !== 8'h00) begin
      errors++;
      $display("FAIL mid_play_reset: state=%0d score=%h required 0/00", bus.state, bus.score_bcd);
    end
  endtask

  task automatic test_high_score();
    int p;
    start_round();
    do_passes(7, p);
    end_round();
    checks++;
`ifdef HIGH_SCORE_EN
    if (bus.high_score_bcd !== 8'h07) begin
      errors++;
      $display("FAIL hs_round1: got %h required 07", bus.high_score_bcd);
    end
`else
    if (bus.high_score_bcd !== 8'h00) begin
      errors++;
      $display("FAIL hs_round1: got %h required 00", bus.high_score_bcd);
    end
`endif
    start_round();
    do_passes(3, p);
    end_round();
    checks++;
    if (bus.score_bcd !== 8'h03 || bus.state !== 2'd3) begin
      errors++;
      $display("FAIL round2: score=%h state=%0d required 03/3", bus.score_bcd, bus.state);
    end
    checks++;
`ifdef HIGH_SCORE_EN
    if (bus.high_score_bcd !== 8'h07) begin
      errors++;
      $display("FAIL hs_round2: got %h required 07", bus.high_score_bcd);
    end
`else
    if (bus.high_score_bcd !== 8'h00) begin
      errors++;
      $display("FAIL hs_round2: got %h required 00", bus.high_score_bcd);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_start();
    test_pass();
    test_collision();
    test_floor();
    test_saturate();
    test_high_score();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
